// File: rtl/dcache_flush_unit_pkg.sv
// Shared constants and types for the DCache flush unit.
// Default geometry matches the production DCache; instances may override it.
package dcache_flush_unit_pkg;

  localparam int unsigned DCACHE_SETS   = 256;
  localparam int unsigned DCACHE_WAYS   = 4;
  localparam int unsigned DCACHE_TAG_W  = 44;
  localparam int unsigned DCACHE_LINE_W = 128;

  localparam int unsigned DCACHE_IDX_W  = $clog2(DCACHE_SETS);
  localparam int unsigned DCACHE_OFF_W  = $clog2(DCACHE_LINE_W / 8);
  localparam int unsigned DCACHE_ADDR_W = DCACHE_TAG_W + DCACHE_IDX_W + DCACHE_OFF_W;

  // Writeback request for the default cache geometry.
  typedef struct packed {
    logic [DCACHE_ADDR_W-1:0] addr;
    logic [DCACHE_LINE_W-1:0] data;
  } dcache_wb_req_t;

  // Way counter width; a direct-mapped cache still needs one bit.
  function automatic int unsigned way_width(input int unsigned nr_ways);
    return (nr_ways > 1) ? $clog2(nr_ways) : 1;
  endfunction

endpackage

// File: rtl/dcache_flush_unit_if.sv
// Bus bundle between the flush unit and its environment (flush controller,
// DCache tag/data array, writeback path to memory).
// master: the flush unit.  slave: controller/array/memory side.
interface dcache_flush_unit_if
  import dcache_flush_unit_pkg::*;
#(
  parameter int unsigned NR_SETS = DCACHE_SETS,
  parameter int unsigned NR_WAYS = DCACHE_WAYS,
  parameter int unsigned TAG_W   = DCACHE_TAG_W,
  parameter int unsigned LINE_W  = DCACHE_LINE_W
) ();

  localparam int unsigned IDX_W  = $clog2(NR_SETS);
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned ADDR_W = TAG_W + IDX_W + OFF_W;

  // flush controller
  logic              flush_i;
  logic              flush_ack_o;
  logic              busy_o;
  // tag/data array
  logic              arr_req_o;
  logic              arr_gnt_i;
  logic              arr_we_o;
  logic [IDX_W-1:0]  arr_idx_o;
  logic [NR_WAYS-1:0] arr_way_o;
  logic              arr_rvalid_i;
  logic              arr_valid_i;
  logic              arr_dirty_i;
  logic [TAG_W-1:0]  arr_tag_i;
  logic [LINE_W-1:0] arr_data_i;
  // writeback
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [ADDR_W-1:0] wb_addr_o;
  logic [LINE_W-1:0] wb_data_o;
  logic              wb_done_i;
  // statistics
  logic [31:0]       flush_wb_cnt_o;

  modport master (
    input  flush_i, arr_gnt_i, arr_rvalid_i, arr_valid_i, arr_dirty_i,
           arr_tag_i, arr_data_i, wb_ready_i, wb_done_i,
    output flush_ack_o, busy_o, arr_req_o, arr_we_o, arr_idx_o, arr_way_o,
           wb_valid_o, wb_addr_o, wb_data_o, flush_wb_cnt_o
  );

  modport slave (
    output flush_i, arr_gnt_i, arr_rvalid_i, arr_valid_i, arr_dirty_i,
           arr_tag_i, arr_data_i, wb_ready_i, wb_done_i,
    input  flush_ack_o, busy_o, arr_req_o, arr_we_o, arr_idx_o, arr_way_o,
           wb_valid_o, wb_addr_o, wb_data_o, flush_wb_cnt_o
  );

endinterface

// File: rtl/dcache_flush_unit_index_cnt.sv
// flush_index_cnt: set/way walk counter for the flush unit.
// Way is the inner loop, set the outer loop; last_o flags the final line.
module flush_index_cnt
  import dcache_flush_unit_pkg::*;
#(
  parameter int unsigned NR_SETS = DCACHE_SETS,
  parameter int unsigned NR_WAYS = DCACHE_WAYS
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       adv_i,
  output logic [$clog2(NR_SETS)-1:0] idx_o,
  output logic [NR_WAYS-1:0]         way_oh_o,
  output logic                       last_o
);

  localparam int unsigned IDX_W = $clog2(NR_SETS);
  localparam int unsigned WAY_W = way_width(NR_WAYS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NR_SETS - 1);
  localparam logic [WAY_W-1:0] WAY_LAST = WAY_W'(NR_WAYS - 1);

  logic [IDX_W-1:0] idx_reg;
  logic [WAY_W-1:0] way_reg;
  logic             way_last;

  assign way_last = (way_reg == WAY_LAST);
  assign last_o   = way_last && (idx_reg == IDX_LAST);
  assign idx_o    = idx_reg;

  // Step to the next way, rolling over into the next set; wraps after the last line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_reg <= '0;
      way_reg <= '0;
    end else if (clr_i) begin
      idx_reg <= '0;
      way_reg <= '0;
    end else if (adv_i) begin
      if (way_last) begin
        way_reg <= '0;
        idx_reg <= idx_reg + 1'b1;
      end else begin
        way_reg <= way_reg + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NR_WAYS; gi++) begin : g_way_oh
    assign way_oh_o[gi] = (way_reg == WAY_W'(gi));
  end

endmodule

// File: rtl/dcache_flush_unit.sv
// dcache_flush_unit: walks every set/way of the DCache, writes back
// valid+dirty lines, invalidates valid lines and pulses flush_ack_o once.
// Optional feature macro: DCACHE_FLUSH_PERF_EN (cumulative writeback counter
// on flush_wb_cnt_o; tied to zero when undefined).
module dcache_flush_unit
  import dcache_flush_unit_pkg::*;
#(
  parameter int unsigned NR_SETS = DCACHE_SETS,
  parameter int unsigned NR_WAYS = DCACHE_WAYS,
  parameter int unsigned TAG_W   = DCACHE_TAG_W,
  parameter int unsigned LINE_W  = DCACHE_LINE_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  dcache_flush_unit_if.master bus
);

  localparam int unsigned IDX_W  = $clog2(NR_SETS);
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned ADDR_W = TAG_W + IDX_W + OFF_W;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WB_REQ, WB_WAIT, INV, DONE
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } wb_req_t;

  state_e            state_reg, state_next;
  logic              armed_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [LINE_W-1:0] data_reg;

  logic              cnt_clr, cnt_adv, cnt_last;
  logic [IDX_W-1:0]  cnt_idx;
  logic [NR_WAYS-1:0] cnt_way_oh;
  logic              line_latch;
  logic              arr_req, arr_we, wb_valid, flush_ack;
  wb_req_t           wb_req;

  flush_index_cnt #(
    .NR_SETS (NR_SETS),
    .NR_WAYS (NR_WAYS)
  ) u_index_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (cnt_clr),
    .adv_i    (cnt_adv),
    .idx_o    (cnt_idx),
    .way_oh_o (cnt_way_oh),
    .last_o   (cnt_last)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Re-arm whenever the request is low so the controller's lagging request
  // after an ack cannot start a second walk; disarm once a walk completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  armed_reg <= 1'b1;
    else if (!bus.flush_i)      armed_reg <= 1'b1;
    else if (state_reg == DONE) armed_reg <= 1'b0;
  end

  // Capture the line returned by the array read for a possible writeback.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_reg  <= '0;
      data_reg <= '0;
    end else if (line_latch) begin
      tag_reg  <= bus.arr_tag_i;
      data_reg <= bus.arr_data_i;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_next = state_reg;
    cnt_clr    = 1'b0;
    cnt_adv    = 1'b0;
    line_latch = 1'b0;
    arr_req    = 1'b0;
    arr_we     = 1'b0;
    wb_valid   = 1'b0;
    flush_ack  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.flush_i && armed_reg) state_next = RD_REQ;
      end
      RD_REQ: begin
        arr_req = 1'b1;
        if (bus.arr_gnt_i) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.arr_rvalid_i) begin
          line_latch = 1'b1;
          if (bus.arr_valid_i && bus.arr_dirty_i) begin
            state_next = WB_REQ;
          end else if (bus.arr_valid_i) begin
            state_next = INV;
          end else begin
            cnt_adv    = 1'b1;
            state_next = cnt_last ? DONE : RD_REQ;
          end
        end
      end
      WB_REQ: begin
        wb_valid = 1'b1;
        if (bus.wb_ready_i) state_next = WB_WAIT;
      end
      WB_WAIT: begin
        if (bus.wb_done_i) state_next = INV;
      end
      INV: begin
        arr_req = 1'b1;
        arr_we  = 1'b1;
        if (bus.arr_gnt_i) begin
          cnt_adv    = 1'b1;
          state_next = cnt_last ? DONE : RD_REQ;
        end
      end
      DONE: begin
        flush_ack  = 1'b1;
        cnt_clr    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign wb_req.addr = {tag_reg, cnt_idx, {OFF_W{1'b0}}};
  assign wb_req.data = data_reg;

  // Address/way/data are zeroed when not requested so idle outputs are quiet.
  assign bus.flush_ack_o = flush_ack;
  assign bus.busy_o      = (state_reg != IDLE);
  assign bus.arr_req_o   = arr_req;
  assign bus.arr_we_o    = arr_we;
  assign bus.arr_idx_o   = arr_req ? cnt_idx : '0;
  assign bus.arr_way_o   = arr_req ? cnt_way_oh : '0;
  assign bus.wb_valid_o  = wb_valid;
  assign bus.wb_addr_o   = wb_valid ? wb_req.addr : '0;
  assign bus.wb_data_o   = wb_valid ? wb_req.data : '0;

`ifdef DCACHE_FLUSH_PERF_EN
  logic [31:0] wb_cnt_reg;

  // Count accepted writebacks since reset, saturating at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_cnt_reg <= '0;
    end else if (wb_valid && bus.wb_ready_i && (wb_cnt_reg != 32'hFFFF_FFFF)) begin
      wb_cnt_reg <= wb_cnt_reg + 32'd1;
    end
  end

  assign bus.flush_wb_cnt_o = wb_cnt_reg;
`else
  assign bus.flush_wb_cnt_o = 32'h0;
`endif

endmodule
